gb_alu_seq_sub: RTL and testbench

Nibble-serial subtract/compare unit for the GB ALU. It performs SUB, SBC and CP on 8-bit or 16-bit operands using one 4-bit borrow slice, one nibble per cycle, LSB first, in the LR35902 style. It sits between the decode/issue stage and register writeback. Requests and results use valid/ready handshakes, and the unit produces the Z/N/H/C flags.

---
 rtl/gb_alu_pkg.sv | 22 ++
 rtl/gb_alu_sub4_slice.sv | 36 +++
 rtl/gb_alu_seq_sub.sv | 164 ++++++++++++++++
 tb/tb_gb_alu_seq_sub.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_alu_pkg.sv
// Shared definitions for the GB ALU sequential subtract unit.
// Holds the FSM state encoding, nibble counts per operand width and the
// flag bit positions inside the F register.
package gb_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Nibbles processed per operation
  localparam int NIB_BYTE = 2;
  localparam int NIB_WORD = 4;

  // Flag bit positions in the F register
  localparam int F_BIT_Z = 7;
  localparam int F_BIT_N = 6;
  localparam int F_BIT_H = 5;
  localparam int F_BIT_C = 4;

endpackage

// File: rtl/gb_alu_sub4_slice.sv
// Purpose: combinational 4-bit a - b - borrow_in via a + ~b + ~borrow_in.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: i_a/i_b nibble operands, i_borrow borrow-in, o_diff difference,
//        o_borrow borrow-out (inverse of the adder carry-out).
module gb_alu_sub4_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_borrow,
  output logic [3:0] o_diff,
  output logic       o_borrow
);

  logic [3:0] nb;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Two-level carry lookahead on the inverted subtrahend; carry-in is
  // the complement of the borrow-in.
  always_comb begin
    nb   = ~i_b;
    g    = i_a & nb;
    p    = i_a ^ nb;
    c[0] = ~i_borrow;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    o_diff   = p ^ c[3:0];
    o_borrow = ~c[4];
  end

endmodule

// File: rtl/gb_alu_seq_sub.sv
// Purpose: nibble-serial SUB/SBC/CP (8 or 16 bit), LSB nibble first, Z/N/H/C flags.
// Latency: o_valid rises 2 cycles (byte) / MAX_NIB cycles (wide) after the accept edge.
// Backpressure: result, flags and o_wb held in DONE until i_ready; o_ready only in IDLE.
// Ports: i_valid/o_ready request handshake with i_a, i_b, i_wide, i_use_carry,
//        i_carry, i_cmp; o_valid/i_ready result handshake with o_result,
//        o_z/o_n/o_h/o_c flags and o_wb (write back unless CP).
module gb_alu_seq_sub
  import gb_alu_pkg::*;
#(
  parameter int MAX_NIB      = NIB_WORD,
  parameter int FLAG_H_NIB16 = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [4*MAX_NIB-1:0]   i_a,
  input  logic [4*MAX_NIB-1:0]   i_b,
  input  logic                   i_wide,
  input  logic                   i_use_carry,
  input  logic                   i_carry,
  input  logic                   i_cmp,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [4*MAX_NIB-1:0]   o_result,
  output logic                   o_z,
  output logic                   o_n,
  output logic                   o_h,
  output logic                   o_c,
  output logic                   o_wb
);

  localparam int W  = 4 * MAX_NIB;
  localparam int KW = (MAX_NIB > 1) ? $clog2(MAX_NIB) : 1;

  state_e           state_q,  state_d;
  logic [W-1:0]     a_q,      a_d;
  logic [W-1:0]     b_q,      b_d;
  logic             wide_q,   wide_d;
  logic             cmp_q,    cmp_d;
  logic             borrow_q, borrow_d;
  logic [KW-1:0]    k_q,      k_d;
  logic [W-1:0]     result_q, result_d;
  logic             h_q,      h_d;
  logic             c_q,      c_d;

  logic [KW+1:0]    nib_lo;
  logic [KW-1:0]    last_k;
  logic [KW-1:0]    h_k;
  logic [3:0]       slice_diff;
  logic             slice_borrow;
  logic             z_flag;

  // Low bit of the nibble currently being processed
  assign nib_lo = {k_q, 2'b00};

  // H is the borrow arriving at nibble 1 (byte) or nibble FLAG_H_NIB16
  // (wide), i.e. the borrow out of the nibble just below it.
  assign last_k = wide_q ? KW'(MAX_NIB - 1)      : KW'(NIB_BYTE - 1);
  assign h_k    = wide_q ? KW'(FLAG_H_NIB16 - 1) : KW'(0);

  gb_alu_sub4_slice u_slice (
    .i_a      (a_q[nib_lo +: 4]),
    .i_b      (b_q[nib_lo +: 4]),
    .i_borrow (borrow_q),
    .o_diff   (slice_diff),
    .o_borrow (slice_borrow)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    wide_d   = wide_q;
    cmp_d    = cmp_q;
    borrow_d = borrow_q;
    k_d      = k_q;
    result_d = result_q;
    h_d      = h_q;
    c_d      = c_q;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_d = i_a;
          b_d = i_b;
          // Byte mode never looks at the upper operand bits
          if (!i_wide) begin
            a_d[W-1:8] = '0;
            b_d[W-1:8] = '0;
          end
          wide_d   = i_wide;
          cmp_d    = i_cmp;
          borrow_d = i_use_carry & i_carry;
          k_d      = '0;
          result_d = '0;
          h_d      = 1'b0;
          c_d      = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[nib_lo +: 4] = slice_diff;
        borrow_d = slice_borrow;
        if (k_q == h_k) begin
          h_d = slice_borrow;
        end
        if (k_q == last_k) begin
          c_d     = slice_borrow;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      wide_q   <= 1'b0;
      cmp_q    <= 1'b0;
      borrow_q <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      h_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wide_q   <= wide_d;
      cmp_q    <= cmp_d;
      borrow_q <= borrow_d;
      k_q      <= k_d;
      result_q <= result_d;
      h_q      <= h_d;
      c_q      <= c_d;
    end
  end

  // Upper byte of the result is cleared at accept, so only the active
  // width needs testing in byte mode.
  assign z_flag = wide_q ? (result_q == '0) : (result_q[7:0] == 8'h00);

  // Flags and writeback only assert while a result is being presented.
  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_result = result_q;
  assign o_z      = o_valid & z_flag;
  assign o_n      = o_valid;
  assign o_h      = o_valid & h_q;
  assign o_c      = o_valid & c_q;
  assign o_wb     = o_valid & ~cmp_q;

endmodule

// File: tb/tb_gb_alu_seq_sub.sv
// Bench for gb_alu_seq_sub: directed and random requests, arithmetic
// reference model, scoreboard queue consumed by an independent monitor.
module tb_gb_alu_seq_sub;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        i_wide;
  logic        i_use_carry;
  logic        i_carry;
  logic        i_cmp;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_result;
  logic        o_z, o_n, o_h, o_c, o_wb;

  gb_alu_seq_sub dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_wide      (i_wide),
    .i_use_carry (i_use_carry),
    .i_carry     (i_carry),
    .i_cmp       (i_cmp),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_z         (o_z),
    .o_n         (o_n),
    .o_h         (o_h),
    .o_c         (o_c),
    .o_wb        (o_wb)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        h;
    logic        c;
    logic        wb;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_force = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain integer subtraction; a negative result means a borrow.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic wide, input logic uc,
                                 input logic c, input logic cmp);
    exp_t e;
    int   bin;
    int   d;
    int   hd;
    bin = (uc && c) ? 1 : 0;
    if (wide) begin
      d     = int'(a) - int'(b) - bin;
      hd    = int'(a & 16'h0FFF) - int'(b & 16'h0FFF) - bin;
      e.res = d[15:0];
      e.lat = 4;
    end else begin
      d     = int'(a[7:0]) - int'(b[7:0]) - bin;
      hd    = int'(a[3:0]) - int'(b[3:0]) - bin;
      e.res = {8'h00, d[7:0]};
      e.lat = 2;
    end
    e.c   = (d < 0);
    e.h   = (hd < 0);
    e.z   = (e.res == 16'h0000);
    e.wb  = ~cmp;
    e.acc = 0;
    return e;
  endfunction

  task automatic scramble();
    i_a         = 16'($urandom);
    i_b         = 16'($urandom);
    i_wide      = 1'($urandom);
    i_use_carry = 1'($urandom);
    i_carry     = 1'($urandom);
    i_cmp       = 1'($urandom);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic wide,
                      input logic uc, input logic c, input logic cmp);
    exp_t e;
    int   n;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout o_ready=%0b required=1", o_ready);
      return;
    end
    i_valid     = 1'b1;
    i_a         = a;
    i_b         = b;
    i_wide      = wide;
    i_use_carry = uc;
    i_carry     = c;
    i_cmp       = cmp;
    @(posedge i_clk);
    #1;
    e     = model(a, b, wide, uc, c, cmp);
    e.acc = cyc;
    exp_q.push_back(e);
    i_valid = 1'b0;
    scramble();
  endtask

  // Monitor: pops an expectation on the first cycle of each result, then
  // checks that everything stays frozen while the consumer stalls.
  initial begin
    exp_t        e;
    logic        in_res;
    logic        hs_pend;
    int          stall;
    logic [15:0] snap_res;
    logic [4:0]  snap_fl;
    in_res  = 1'b0;
    hs_pend = 1'b0;
    stall   = 0;
    i_ready = 1'b0;
    forever begin
      @(negedge i_clk);
      if (hs_pend) begin
        chk("valid_drop", {31'd0, o_valid}, 32'd0);
        chk("ready_back", {31'd0, o_ready}, 32'd1);
        hs_pend = 1'b0;
        in_res  = 1'b0;
      end
      if (o_valid === 1'b1) begin
        if (!in_res) begin
          in_res = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0h required=none", o_result);
          end else begin
            e = exp_q.pop_front();
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("result", {16'd0, o_result}, {16'd0, e.res});
            chk("flag_z", {31'd0, o_z}, {31'd0, e.z});
            chk("flag_n", {31'd0, o_n}, 32'd1);
            chk("flag_h", {31'd0, o_h}, {31'd0, e.h});
            chk("flag_c", {31'd0, o_c}, {31'd0, e.c});
            chk("wb", {31'd0, o_wb}, {31'd0, e.wb});
            chk("ready_busy", {31'd0, o_ready}, 32'd0);
          end
          snap_res = o_result;
          snap_fl  = {o_z, o_n, o_h, o_c, o_wb};
          stall    = (stall_force >= 0) ? stall_force : $urandom_range(0, 3);
          stall_force = -1;
        end else begin
          chk("hold_result", {16'd0, o_result}, {16'd0, snap_res});
          chk("hold_flags", {27'd0, o_z, o_n, o_h, o_c, o_wb}, {27'd0, snap_fl});
          chk("hold_ready", {31'd0, o_ready}, 32'd0);
        end
        if (stall > 0) begin
          i_ready = 1'b0;
          stall--;
        end else begin
          i_ready = 1'b1;
          hs_pend = 1'b1;
        end
      end else begin
        in_res  = 1'b0;
        i_ready = 1'($urandom);
      end
    end
  end

  initial begin
    exp_t dummy;
    int   n;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    scramble();
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_result", {16'd0, o_result}, 32'd0);
    chk("rst_flags", {27'd0, o_z, o_n, o_h, o_c, o_wb}, 32'd0);

    // Directed cases
    send(16'h003E, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'hAB10, 16'hCD20, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'h0042, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h1000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    stall_force = 5;
    send(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a wide operation discards it
    send(16'h5678, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    dummy = exp_q.pop_back();
    @(negedge i_clk);
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    chk("midrst_result", {16'd0, o_result}, 32'd0);
    chk("midrst_flags", {27'd0, o_z, o_n, o_h, o_c, o_wb}, 32'd0);
    send(16'h00A5, 16'h005A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    end

    n = 0;
    while ((exp_q.size() != 0 || o_valid === 1'b1) && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    repeat (2) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
